// File: rtl/gnn_mac_scheduler.sv
// Time-multiplexed sequencer for the 4-node two-layer MLP: one shared MAC, 25 cycles per node.
// Optional busy-cycle counter output cyc_cnt is enabled with GNN_CYCLE_CNT_EN.
module gnn_mac_scheduler #(
  parameter int N_NODES = 4,
  parameter int DW      = 5,
  parameter int OW      = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_ready,
  input  logic          abort,
  output logic [3:0]    feat_addr,
  input  logic [DW-1:0] feat_data,
  output logic [3:0]    w1_addr,
  input  logic [DW-1:0] w1_data,
  output logic [2:0]    w2_addr,
  input  logic [DW-1:0] w2_data,
  output logic          busy,
  output logic          out_valid,
  output logic [1:0]    out_node,
  output logic [OW-1:0] out0,
  output logic [OW-1:0] out1,
  output logic [3:0]    out_ready,
  output logic          done
`ifdef GNN_CYCLE_CNT_EN
  ,
  output logic [7:0]    cyc_cnt
`endif
);

  localparam int PW1 = 2 * DW;
  localparam int HW  = PW1 + 2;
  localparam int PW2 = HW + DW;
  localparam int AW  = PW2 + 2;
  localparam logic [1:0] LAST_NODE = 2'(N_NODES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      node_r, node_nxt_s;
  logic [1:0]      hid_r, hid_nxt_s;
  logic [1:0]      feat_r, feat_nxt_s;
  logic            o_r, o_nxt_s;
  logic [HW-1:0]   h_r [4];
  logic [AW-1:0]   acc_r [2];
  logic [PW1-1:0]  prod1_s;
  logic [PW2-1:0]  prod2_s;
  logic            start_s, wr_s, enter_l1_s, enter_l2_s;

  assign start_s    = (state_r == IDLE) && in_ready && !abort;
  assign wr_s       = (state_r == WR) && !abort;
  assign enter_l1_s = (state_nxt_s == L1) && (state_r != L1);
  assign enter_l2_s = (state_nxt_s == L2) && (state_r != L2);
  assign prod1_s    = PW1'(feat_data) * PW1'(w1_data);
  assign prod2_s    = PW2'(h_r[hid_r]) * PW2'(w2_data);

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      node_r  <= 2'd0;
      hid_r   <= 2'd0;
      feat_r  <= 2'd0;
      o_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      node_r  <= node_nxt_s;
      hid_r   <= hid_nxt_s;
      feat_r  <= feat_nxt_s;
      o_r     <= o_nxt_s;
    end
  end

  // Next-state and loop-counter sequencing; abort always lands in IDLE
  always_comb begin
    state_nxt_s = state_r;
    node_nxt_s  = node_r;
    hid_nxt_s   = hid_r;
    feat_nxt_s  = feat_r;
    o_nxt_s     = o_r;
    if (abort) begin
      state_nxt_s = IDLE;
      node_nxt_s  = 2'd0;
      hid_nxt_s   = 2'd0;
      feat_nxt_s  = 2'd0;
      o_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_ready) begin
            state_nxt_s = L1;
            node_nxt_s  = 2'd0;
            hid_nxt_s   = 2'd0;
            feat_nxt_s  = 2'd0;
            o_nxt_s     = 1'b0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        L1: begin
          feat_nxt_s = feat_r + 2'd1;
          if (feat_r == 2'd3) begin
            hid_nxt_s = hid_r + 2'd1;
            if (hid_r == 2'd3) begin
              state_nxt_s = L2;
              o_nxt_s     = 1'b0;
            end else begin
              state_nxt_s = L1;
            end
          end else begin
            hid_nxt_s = hid_r;
          end
        end
        L2: begin
          o_nxt_s = ~o_r;
          if (o_r) begin
            hid_nxt_s = hid_r + 2'd1;
            if (hid_r == 2'd3) begin
              state_nxt_s = WR;
            end else begin
              state_nxt_s = L2;
            end
          end else begin
            hid_nxt_s = hid_r;
          end
        end
        WR: begin
          hid_nxt_s  = 2'd0;
          feat_nxt_s = 2'd0;
          o_nxt_s    = 1'b0;
          if (node_r == LAST_NODE) begin
            state_nxt_s = IDLE;
            node_nxt_s  = 2'd0;
          end else begin
            state_nxt_s = L1;
            node_nxt_s  = node_r + 2'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Address registers load the next-cycle counters so they match the active MAC step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_addr <= 4'd0;
      w1_addr   <= 4'd0;
      w2_addr   <= 3'd0;
    end else begin
      feat_addr <= (state_nxt_s == L1) ? {node_nxt_s, feat_nxt_s} : 4'd0;
      w1_addr   <= (state_nxt_s == L1) ? {feat_nxt_s, hid_nxt_s}  : 4'd0;
      w2_addr   <= (state_nxt_s == L2) ? {hid_nxt_s, o_nxt_s}     : 3'd0;
    end
  end

  // Layer accumulators: cleared on phase entry, one MAC per L1/L2 cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) h_r[i] <= {HW{1'b0}};
      acc_r[0] <= {AW{1'b0}};
      acc_r[1] <= {AW{1'b0}};
    end else begin
      if (enter_l1_s) begin
        for (int i = 0; i < 4; i++) h_r[i] <= {HW{1'b0}};
      end else if (state_r == L1) begin
        h_r[hid_r] <= h_r[hid_r] + HW'(prod1_s);
      end
      if (enter_l2_s) begin
        acc_r[0] <= {AW{1'b0}};
        acc_r[1] <= {AW{1'b0}};
      end else if (state_r == L2) begin
        acc_r[o_r] <= acc_r[o_r] + AW'(prod2_s);
      end
    end
  end

  // Result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_node  <= 2'd0;
      out0      <= {OW{1'b0}};
      out1      <= {OW{1'b0}};
      out_ready <= 4'd0;
      done      <= 1'b0;
    end else begin
      busy      <= (state_nxt_s != IDLE);
      out_valid <= wr_s;
      done      <= wr_s && (node_r == LAST_NODE);
      if (wr_s) begin
        out0      <= OW'(acc_r[0]);
        out1      <= OW'(acc_r[1]);
        out_node  <= node_r;
        out_ready <= out_ready | (4'd1 << node_r);
      end else if (start_s) begin
        out_ready <= 4'd0;
      end
    end
  end

`ifdef GNN_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on start, frozen once back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= 8'd0;
    end else if (start_s) begin
      cyc_cnt <= 8'd0;
    end else if (state_r != IDLE) begin
      cyc_cnt <= cyc_cnt + 8'd1;
    end
  end
`else
  // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_gnn_mac_scheduler.sv
// Bench for gnn_mac_scheduler: node-level arithmetic model checked every cycle plus directed literal checks.
module tb_gnn_mac_scheduler;

  logic        clk, rst_n, in_ready, abort;
  logic [3:0]  feat_addr, w1_addr;
  logic [2:0]  w2_addr;
  logic [4:0]  feat_data, w1_data, w2_data;
  logic        busy, out_valid, done;
  logic [1:0]  out_node;
  logic [20:0] out0, out1;
  logic [3:0]  out_ready;
`ifdef GNN_CYCLE_CNT_EN
  logic [7:0]  cyc_cnt;
`endif

  logic [4:0] feat_mem [16];
  logic [4:0] w1_mem [16];
  logic [4:0] w2_mem [8];

  assign feat_data = feat_mem[feat_addr];
  assign w1_data   = w1_mem[w1_addr];
  assign w2_data   = w2_mem[w2_addr];

  gnn_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .abort(abort),
    .feat_addr(feat_addr), .feat_data(feat_data),
    .w1_addr(w1_addr), .w1_data(w1_data),
    .w2_addr(w2_addr), .w2_data(w2_data),
    .busy(busy), .out_valid(out_valid), .out_node(out_node),
    .out0(out0), .out1(out1), .out_ready(out_ready), .done(done)
`ifdef GNN_CYCLE_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  // Node result straight from the MLP definition
  function automatic int model_out(input int n, input int k);
    int s, h;
    s = 0;
    for (int j = 0; j < 4; j++) begin
      h = 0;
      for (int i = 0; i < 4; i++) h += int'(feat_mem[n*4+i]) * int'(w1_mem[i*4+j]);
      s += h * int'(w2_mem[j*2+k]);
    end
    return s;
  endfunction

  // Expected {feat_addr, w1_addr, w2_addr} for cycle t of a run (25 cycles per node)
  function automatic logic [10:0] exp_addrs(input bit act, input int t);
    int p, n;
    p = t % 25;
    n = t / 25;
    if (!act || p == 24) return 11'd0;
    if (p < 16) return {2'(n), 2'(p % 4), 2'(p % 4), 2'(p / 4), 3'b000};
    return {8'h00, 2'((p - 16) / 2), 1'((p - 16) % 2)};
  endfunction

  bit          m_active = 1'b0;
  int          m_t = 0;
  int          m_cyc = 0;
  bit          m_valid = 1'b0, m_done = 1'b0;
  logic [1:0]  m_node = 2'd0;
  logic [20:0] m_out0 = 21'd0, m_out1 = 21'd0;
  logic [3:0]  m_ready = 4'd0;

  // Run-level model: a run is 100 cycles, node n written at the end of its 25th cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_t <= 0; m_cyc <= 0; m_valid <= 1'b0; m_done <= 1'b0;
      m_node <= 2'd0; m_out0 <= 21'd0; m_out1 <= 21'd0; m_ready <= 4'd0;
    end else begin
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      if (m_active) begin
        m_cyc <= m_cyc + 1;
        if (abort) begin
          m_active <= 1'b0;
        end else begin
          if (m_t % 25 == 24) begin
            m_valid <= 1'b1;
            m_node  <= 2'(m_t / 25);
            m_out0  <= 21'(model_out(m_t / 25, 0));
            m_out1  <= 21'(model_out(m_t / 25, 1));
            m_ready[m_t / 25] <= 1'b1;
            if (m_t / 25 == 3) begin
              m_done   <= 1'b1;
              m_active <= 1'b0;
            end
          end
          m_t <= m_t + 1;
        end
      end else if (in_ready && !abort) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_cyc    <= 0;
        m_ready  <= 4'd0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [61:0] got, exp;
    got = {busy, out_valid, out_node, out0, out1, out_ready, done, feat_addr, w1_addr, w2_addr};
    exp = {m_active, m_valid, m_node, m_out0, m_out1, m_ready, m_done, exp_addrs(m_active, m_t)};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
`ifdef GNN_CYCLE_CNT_EN
    n_checks++;
    if (cyc_cnt === 8'(m_cyc)) n_pass++;
    else $display("FAIL cyc_model t=%0t got=%0d expected=%0d", $time, cyc_cnt, m_cyc);
`endif
  end

  task automatic load_mem(input int mode, input int v);
    for (int a = 0; a < 16; a++) begin
      feat_mem[a] = (mode == 0) ? 5'(v) : 5'(a / 4 + 1);
      w1_mem[a]   = (mode == 0) ? 5'(v) : 5'd1;
    end
    for (int a = 0; a < 8; a++) w2_mem[a] = (mode == 0) ? 5'(v) : ((a % 2 == 0) ? 5'd2 : 5'd3);
  endtask

  // One full run; node n must give a0+s0*n / a1+s1*n at cycle 25*(n+1)
  task automatic run_expect(input string tag, input int a0, input int s0, input int a1, input int s1);
    int idx;
    bit fin;
    idx = 0;
    fin = 1'b0;
    @(negedge clk); in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_ready_cleared"}, out_ready, 0);
    for (int k = 1; k <= 130 && !fin; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk({tag, "_node"}, out_node, idx);
        chk({tag, "_latency"}, k, 25 * (idx + 1));
        chk({tag, "_out0"}, out0, a0 + s0 * idx);
        chk({tag, "_out1"}, out1, a1 + s1 * idx);
        chk({tag, "_done"}, done, (idx == 3) ? 1 : 0);
        if (idx == 3) fin = 1'b1;
        idx++;
      end
    end
    chk({tag, "_node_count"}, idx, 4);
    chk({tag, "_ready_all"}, out_ready, 4'hF);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_k;
    int valid_seen;
    rst_n = 1'b0; in_ready = 1'b0; abort = 1'b0;
    load_mem(0, 1);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, out_valid, out_node, out0, out1, out_ready, done,
                          feat_addr, w1_addr, w2_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_expect("ones", 16, 0, 16, 0);
`ifdef GNN_CYCLE_CNT_EN
    chk("cyc_full_run", cyc_cnt, 100);
`endif

    load_mem(0, 31);
    run_expect("max", 476656, 0, 476656, 0);

    load_mem(1, 0);
    run_expect("distinct", 32, 32, 48, 48);

    // Abort during node 2 layer 2
    valid_seen = 0;
    @(negedge clk); in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy_drop", busy, 0);
    chk("abort_ready_kept", out_ready, 4'b0011);
    chk("abort_out0_kept", out0, 64);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    chk("abort_valid_count", valid_seen, 2);
    run_expect("restart", 32, 32, 48, 48);

    // Abort and start together in IDLE: abort wins
    @(negedge clk); abort = 1'b1; in_ready = 1'b1;
    @(negedge clk); abort = 1'b0; in_ready = 1'b0;
    chk("abort_beats_start", busy, 0);
    @(negedge clk);
    chk("abort_beats_start_hold", busy, 0);

`ifdef GNN_CYCLE_CNT_EN
    @(negedge clk); in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
    for (int k = 1; k <= 29; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("cyc_abort_30", cyc_cnt, 30);
    repeat (3) @(negedge clk);
    chk("cyc_abort_frozen", cyc_cnt, 30);
`endif

    // in_ready held: ignored while busy, second run on the first IDLE edge, then reset mid-run
    load_mem(0, 1);
    done_k = 0;
    @(negedge clk); in_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (done && done_k == 0) done_k = k;
      if (k == 101) chk("hold_rerun_busy", busy, 1);
      if (k == 126) chk("hold_rerun_node0", {out_valid, out_node}, 3'b100);
    end
    chk("hold_first_done", done_k, 100);
    #2 rst_n = 1'b0; in_ready = 1'b0;
    #1 chk("async_reset_outputs", {busy, out_valid, out_node, out0, out1, out_ready, done,
                                   feat_addr, w1_addr, w2_addr}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
